// File: rtl/dekatron_pkg.sv
// Shared types and one-hot/binary helpers for the dekatron ring counter.
// Helpers work at the widest supported ring (10 positions, 4 bits); callers cast to their width.
package dekatron_pkg;

    localparam int unsigned MAX_RADIX = 10;
    localparam int unsigned MAX_DW    = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CARRY = 1'b1
    } dek_state_e;

    // Encode a one-hot ring position as its binary index.
    function automatic logic [MAX_DW-1:0] onehot_to_bin(input logic [MAX_RADIX-1:0] oh);
        logic [MAX_DW-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_RADIX; i++) begin
            if (oh[i]) begin
                b = b | MAX_DW'(i);
            end
        end
        return b;
    endfunction

    // Decode a binary digit to a one-hot ring position; values >= radix land on position 0.
    function automatic logic [MAX_RADIX-1:0] bin_to_onehot(input logic [MAX_DW-1:0] b,
                                                           input int unsigned radix);
        logic [MAX_RADIX-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_RADIX; i++) begin
            if ((MAX_DW'(i) == b) && (i < int'(radix))) begin
                oh[i] = 1'b1;
            end
        end
        if (oh == '0) begin
            oh[0] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/dekatron_ring.sv
// One dekatron digit: a one-hot ring that rotates one position per Step.
// CarryOut flags the wrap that the current Step will cause at the coming edge.
module dekatron_ring
    import dekatron_pkg::*;
#(
    parameter int unsigned RADIX = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Step,
    input  logic             Reverse,
    input  logic             Set,
    input  logic [RADIX-1:0] In,
    output logic [RADIX-1:0] Out,
    output logic             CarryOut
);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Out <= RADIX'(1);
        end else if (Set) begin
            Out <= In;
        end else if (Step) begin
            Out <= Reverse ? {Out[0], Out[RADIX-1:1]} : {Out[RADIX-2:0], Out[RADIX-1]};
        end
    end

    assign CarryOut = Step & (Reverse ? Out[0] : Out[RADIX-1]);

endmodule

// File: rtl/dekatron_ring_counter.sv
// Multi-digit up/down counter of one-hot rings; carry ripples one digit per clock.
// Define DEKATRON_WRAP_FLAG_EN to add the registered Wrap pulse output.
module dekatron_ring_counter
    import dekatron_pkg::*;
#(
    parameter  int unsigned DIGITS = 6,
    parameter  int unsigned RADIX  = 8,
    localparam int unsigned DW     = $clog2(RADIX)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Request,
    input  logic                 Reverse,
    input  logic                 Load,
    input  logic [DIGITS*DW-1:0] LoadValue,
    output logic                 Ready,
    output logic [DIGITS*DW-1:0] Out,
    output logic                 Zero
`ifdef DEKATRON_WRAP_FLAG_EN
    ,
    output logic                 Wrap
`endif
);

    localparam int unsigned PW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [0:0]  ST_IDLE  = 1'(IDLE);
    localparam logic [0:0]  ST_CARRY = 1'(CARRY);

    logic [0:0]        state, state_next;
    logic [PW-1:0]     ptr, ptr_next;
    logic              dir, dir_next;
    logic              set_all;
    logic              ring_dir;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] at_zero;
    logic              carry_any;

    // Only the stepping digit can carry, so the OR is the carry of that digit.
    assign carry_any = |carry;

    // Step/Set decode: IDLE drives digit 0 from inputs, CARRY drives digit[ptr] with latched dir.
    always_comb begin
        step     = '0;
        set_all  = 1'b0;
        ring_dir = dir;
        if (state == ST_IDLE) begin
            ring_dir = Reverse;
            if (Load) begin
                set_all = 1'b1;
            end else begin
                step[0] = Request;
            end
        end else begin
            for (int i = 1; i < int'(DIGITS); i++) begin
                if (ptr == PW'(i)) begin
                    step[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            dir   <= dir_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        dir_next   = dir;
        case (state)
            ST_IDLE: begin
                if (!Load && Request) begin
                    dir_next = Reverse;
                    if (carry_any && (DIGITS > 1)) begin
                        state_next = ST_CARRY;
                        ptr_next   = PW'(1);
                    end
                end
            end
            ST_CARRY: begin
                if (carry_any && (ptr != PW'(DIGITS - 1))) begin
                    ptr_next = PW'(ptr + 1'b1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [RADIX-1:0] ring_q;
        logic [RADIX-1:0] load_oh;

        assign load_oh = RADIX'(bin_to_onehot(MAX_DW'(LoadValue[i*DW +: DW]), RADIX));

        dekatron_ring #(
            .RADIX (RADIX)
        ) u_ring (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .Step     (step[i]),
            .Reverse  (ring_dir),
            .Set      (set_all),
            .In       (load_oh),
            .Out      (ring_q),
            .CarryOut (carry[i])
        );

        assign Out[i*DW +: DW] = DW'(onehot_to_bin(MAX_RADIX'(ring_q)));
        assign at_zero[i]      = ring_q[0];
    end

    assign Ready = (state == ST_IDLE);
    assign Zero  = Ready & (&at_zero);

`ifdef DEKATRON_WRAP_FLAG_EN
    // A carry out of the MSD (or of the only digit) is a full-counter wrap.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Wrap <= 1'b0;
        end else begin
            Wrap <= carry_any &&
                    (((state == ST_IDLE) && (DIGITS == 1)) ||
                     ((state == ST_CARRY) && (ptr == PW'(DIGITS - 1))));
        end
    end
`endif

endmodule

// File: tb/tb_dekatron_ring_counter.sv
// Bench for dekatron_ring_counter: vector table, hand sequences, and random ops against an integer model.
// Wrap checks are compiled in only with DEKATRON_WRAP_FLAG_EN.
module tb_dekatron_ring_counter;

    localparam int D   = 6;
    localparam int R   = 8;
    localparam int W   = 18;
    localparam int MOD = 262144;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Request = 1'b0;
    logic         Reverse = 1'b0;
    logic         Load = 1'b0;
    logic [W-1:0] LoadValue = '0;
    logic         Ready;
    logic [W-1:0] Out;
    logic         Zero;
    logic         Wrap;

    logic         b_request = 1'b0;
    logic         b_reverse = 1'b0;
    logic         b_load = 1'b0;
    logic [11:0]  b_load_value = '0;
    logic         b_ready;
    logic [11:0]  b_out;
    logic         b_zero;
    logic         b_wrap;

    int nvec = 0;
    int nerr = 0;

    dekatron_ring_counter #(.DIGITS(D), .RADIX(R)) u_dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Request   (Request),
        .Reverse   (Reverse),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Ready     (Ready),
        .Out       (Out),
        .Zero      (Zero)
`ifdef DEKATRON_WRAP_FLAG_EN
        ,
        .Wrap      (Wrap)
`endif
    );

    dekatron_ring_counter #(.DIGITS(3), .RADIX(10)) u_bcd (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Request   (b_request),
        .Reverse   (b_reverse),
        .Load      (b_load),
        .LoadValue (b_load_value),
        .Ready     (b_ready),
        .Out       (b_out),
        .Zero      (b_zero)
`ifdef DEKATRON_WRAP_FLAG_EN
        ,
        .Wrap      (b_wrap)
`endif
    );

`ifndef DEKATRON_WRAP_FLAG_EN
    assign Wrap   = 1'b0;
    assign b_wrap = 1'b0;
`endif

    always #5 Clk = ~Clk;

    typedef struct {
        string        name;
        logic         ld;
        logic [W-1:0] lv;
        logic         rq;
        logic         rv;
        logic [W-1:0] exp_out;
        int           exp_lat;
        logic         exp_zero;
        logic         exp_wrap;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Apply one operation, then wait (bounded) for Ready; lat = cycles Ready stayed low.
    task automatic apply(input logic ld, input logic [W-1:0] lv, input logic rq, input logic rv,
                         output int lat, output logic wr);
        Load = ld; LoadValue = lv; Request = rq; Reverse = rv;
        cycle();
        Load = 1'b0; Request = 1'b0;
        Reverse = 1'($urandom); LoadValue = W'($urandom);
        lat = 0;
        while (Ready !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        wr = Wrap;
    endtask

    task automatic b_apply(input logic ld, input logic [11:0] lv, input logic rq, input logic rv,
                           output int lat, output logic wr);
        b_load = ld; b_load_value = lv; b_request = rq; b_reverse = rv;
        cycle();
        b_load = 1'b0; b_request = 1'b0; b_reverse = 1'($urandom);
        lat = 0;
        while (b_ready !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        wr = b_wrap;
    endtask

    function automatic int dig(input int v, input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * R;
        return (v / p) % R;
    endfunction

    // Counter as an integer modulo R**D: ripple length = run of boundary digits above the LSD.
    task automatic model_step(inout int v, input logic rv, output int k, output logic wr);
        int  edge_digit;
        bit  run;
        edge_digit = rv ? 0 : R - 1;
        k = 0;
        run = 1'b1;
        for (int i = 0; i < D - 1; i++) begin
            if (run && dig(v, i) == edge_digit) k++;
            else run = 1'b0;
        end
        wr = rv ? (v == 0) : (v == MOD - 1);
        v = rv ? (v + MOD - 1) % MOD : (v + 1) % MOD;
    endtask

    initial begin
        vec_t tbl[13];
        int   lat;
        logic wr;
        int   mv;
        int   k;
        logic mwr;

        tbl[0]  = '{"load7",       1'b1, 18'o000007, 1'b0, 1'b0, 18'o000007, 0, 1'b0, 1'b0};
        tbl[1]  = '{"up7",         1'b0, 18'o000000, 1'b1, 1'b0, 18'o000010, 1, 1'b0, 1'b0};
        tbl[2]  = '{"loadmax",     1'b1, 18'o777777, 1'b0, 1'b0, 18'o777777, 0, 1'b0, 1'b0};
        tbl[3]  = '{"upmax",       1'b0, 18'o000000, 1'b1, 1'b0, 18'o000000, 5, 1'b1, 1'b1};
        tbl[4]  = '{"down0",       1'b0, 18'o000000, 1'b1, 1'b1, 18'o777777, 5, 1'b0, 1'b1};
        tbl[5]  = '{"load_beats",  1'b1, 18'o000123, 1'b1, 1'b0, 18'o000123, 0, 1'b0, 1'b0};
        tbl[6]  = '{"down123",     1'b0, 18'o000000, 1'b1, 1'b1, 18'o000122, 0, 1'b0, 1'b0};
        tbl[7]  = '{"load100",     1'b1, 18'o000100, 1'b0, 1'b0, 18'o000100, 0, 1'b0, 1'b0};
        tbl[8]  = '{"down100",     1'b0, 18'o000000, 1'b1, 1'b1, 18'o000077, 2, 1'b0, 1'b0};
        tbl[9]  = '{"load0",       1'b1, 18'o000000, 1'b0, 1'b0, 18'o000000, 0, 1'b1, 1'b0};
        tbl[10] = '{"up0",         1'b0, 18'o000000, 1'b1, 1'b0, 18'o000001, 0, 1'b0, 1'b0};
        tbl[11] = '{"load7777",    1'b1, 18'o007777, 1'b0, 1'b0, 18'o007777, 0, 1'b0, 1'b0};
        tbl[12] = '{"up7777",      1'b0, 18'o000000, 1'b1, 1'b0, 18'o010000, 4, 1'b0, 1'b0};

        // Reset
        Rst_n = 1'b0;
        cycle();
        check("rst_out", 64'(Out), 64'd0);
        check("rst_ready", 64'(Ready), 64'd1);
        check("rst_zero", 64'(Zero), 64'd1);
        check("rst_bcd_out", 64'(b_out), 64'd0);
`ifdef DEKATRON_WRAP_FLAG_EN
        check("rst_wrap", 64'(Wrap), 64'd0);
`endif
        Rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].ld, tbl[i].lv, tbl[i].rq, tbl[i].rv, lat, wr);
            check({tbl[i].name, "_out"}, 64'(Out), 64'(tbl[i].exp_out));
            check({tbl[i].name, "_lat"}, 64'(lat), 64'(tbl[i].exp_lat));
            check({tbl[i].name, "_zero"}, 64'(Zero), 64'(tbl[i].exp_zero));
`ifdef DEKATRON_WRAP_FLAG_EN
            check({tbl[i].name, "_wrap"}, 64'(wr), 64'(tbl[i].exp_wrap));
`endif
        end

`ifdef DEKATRON_WRAP_FLAG_EN
        // Wrap is a single-cycle pulse
        apply(1'b1, 18'o000000, 1'b0, 1'b0, lat, wr);
        apply(1'b0, 18'o000000, 1'b1, 1'b1, lat, wr);
        check("wrap_pulse", 64'(wr), 64'd1);
        cycle();
        check("wrap_one_cycle", 64'(Wrap), 64'd0);
`endif

        // Request, Load and Reverse held during CARRY are ignored
        apply(1'b1, 18'o000777, 1'b0, 1'b0, lat, wr);
        Request = 1'b1; Reverse = 1'b0;
        cycle();
        Load = 1'b1; LoadValue = 18'o555555; Reverse = 1'b1;
        check("busy_ready", 64'(Ready), 64'd0);
        check("busy_zero", 64'(Zero), 64'd0);
        lat = 0;
        while (Ready !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        Request = 1'b0; Load = 1'b0; Reverse = 1'b0;
        check("busy_lat", 64'(lat), 64'd3);
        check("busy_out", 64'(Out), 64'(18'o001000));

        // Reset in the middle of a full ripple
        apply(1'b1, 18'o777777, 1'b0, 1'b0, lat, wr);
        Request = 1'b1; Reverse = 1'b0;
        cycle();
        Request = 1'b0;
        check("mid_busy", 64'(Ready), 64'd0);
        cycle();
        Rst_n = 1'b0;
        cycle();
        Rst_n = 1'b1;
        check("mid_rst_out", 64'(Out), 64'd0);
        check("mid_rst_ready", 64'(Ready), 64'd1);
        check("mid_rst_zero", 64'(Zero), 64'd1);
`ifdef DEKATRON_WRAP_FLAG_EN
        check("mid_rst_wrap", 64'(Wrap), 64'd0);
`endif
        cycle();
        check("mid_rst_hold", 64'(Out), 64'd0);
        check("mid_rst_hold_rdy", 64'(Ready), 64'd1);

        // RADIX=10 instance (BCD digits)
        b_apply(1'b1, 12'h009, 1'b0, 1'b0, lat, wr);
        check("bcd_load9", 64'(b_out), 64'h009);
        b_apply(1'b0, 12'h000, 1'b1, 1'b0, lat, wr);
        check("bcd_up9", 64'(b_out), 64'h010);
        check("bcd_up9_lat", 64'(lat), 64'd1);
        b_apply(1'b1, 12'h0C5, 1'b0, 1'b0, lat, wr);
        check("bcd_load_oor", 64'(b_out), 64'h005);
        b_apply(1'b1, 12'h999, 1'b0, 1'b0, lat, wr);
        b_apply(1'b0, 12'h000, 1'b1, 1'b0, lat, wr);
        check("bcd_up999", 64'(b_out), 64'h000);
        check("bcd_up999_lat", 64'(lat), 64'd2);
        check("bcd_up999_zero", 64'(b_zero), 64'd1);
`ifdef DEKATRON_WRAP_FLAG_EN
        check("bcd_up999_wrap", 64'(wr), 64'd1);
`endif
        b_apply(1'b0, 12'h000, 1'b1, 1'b1, lat, wr);
        check("bcd_down0", 64'(b_out), 64'h999);
        b_apply(1'b1, 12'hFFF, 1'b0, 1'b0, lat, wr);
        check("bcd_load_fff", 64'(b_out), 64'h000);

        // Random operations against the integer model
        mv = int'($urandom_range(0, MOD - 1));
        apply(1'b1, W'(mv), 1'b0, 1'b0, lat, wr);
        check("rnd_init", 64'(Out), 64'(mv));
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [W-1:0] lv;
            logic rv;
            r = $urandom_range(0, 9);
            rv = 1'($urandom);
            if (r < 3) begin
                lv = '0;
                for (int i = 0; i < D; i++) begin
                    case ($urandom_range(0, 2))
                        0:       lv[i*3 +: 3] = 3'd0;
                        1:       lv[i*3 +: 3] = 3'd7;
                        default: lv[i*3 +: 3] = 3'($urandom);
                    endcase
                end
                mv = int'(lv);
                k = 0;
                mwr = 1'b0;
                apply(1'b1, lv, (r == 0), rv, lat, wr);
            end else begin
                model_step(mv, rv, k, mwr);
                apply(1'b0, W'($urandom), 1'b1, rv, lat, wr);
            end
            check($sformatf("rnd%0d_out", n), 64'(Out), 64'(mv));
            check($sformatf("rnd%0d_lat", n), 64'(lat), 64'(k));
            check($sformatf("rnd%0d_zero", n), 64'(Zero), 64'(mv == 0));
`ifdef DEKATRON_WRAP_FLAG_EN
            check($sformatf("rnd%0d_wrap", n), 64'(wr), 64'(mwr));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
